// File: rtl/cam_ctrl_pkg.sv
// Shared types and constants for the camera line-buffer controller.
package cam_ctrl_pkg;

  localparam int PIX_W        = 4;
  localparam int DEF_LINE_LEN = 120;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    CAPTURE   = 2'd2,
    DROP      = 2'd3
  } cap_state_t;

endpackage

// File: rtl/cam_line_ctrl_if.sv
// Bus-reader side of the line buffer: single-nibble reads plus bank release.
interface cam_rd_if #(parameter int IDX_W = 7);
  import cam_ctrl_pkg::*;

  logic             rd_req;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_ack;
  logic [PIX_W-1:0] rd_data;
  logic             rd_err;
  logic             line_done;
  logic             line_ready;

  modport master (output rd_req, rd_idx, line_done,
                  input  rd_ack, rd_data, rd_err, line_ready);
  modport slave  (input  rd_req, rd_idx, line_done,
                  output rd_ack, rd_data, rd_err, line_ready);

endinterface

// File: rtl/cam_rd_port.sv
// Read-request pipeline: address issue, RAM latency, registered ack/data/err.
module cam_rd_port
  import cam_ctrl_pkg::*;
#(
  parameter int LINE_LEN = DEF_LINE_LEN,
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              line_ready,
  input  logic [ADDR_W-1:0] rbase,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              rd_ack,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_err
);

  localparam int STAGES = 1;
  localparam logic [IDX_W:0] LEN_I = (IDX_W+1)'(LINE_LEN);

  logic [STAGES:0] vld_pipe;
  logic            busy, idx_ok, go, bad;

  // The ack cycle counts as busy so a request can never overlap its own response.
  assign busy   = (|vld_pipe) | rd_ack;
  assign idx_ok = {1'b0, rd_idx} < LEN_I;
  assign go     = rd_req && !busy && line_ready && idx_ok;
  assign bad    = rd_req && !busy && !(line_ready && idx_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      ram_raddr <= '0;
      rd_ack    <= 1'b0;
      rd_err    <= 1'b0;
      rd_data   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], go};
      rd_ack   <= 1'b0;
      rd_err   <= 1'b0;
      if (go)
        ram_raddr <= rbase + ADDR_W'(rd_idx);
      if (bad) begin
        rd_ack  <= 1'b1;
        rd_err  <= 1'b1;
        rd_data <= '0;
      end else if (vld_pipe[STAGES]) begin
        // address was registered two edges ago; RAM output is now stable
        rd_ack  <= 1'b1;
        rd_data <= ram_rdata;
      end
    end
  end

endmodule

// File: rtl/cam_line_ctrl.sv
// Camera line-buffer controller: ping-pong capture into RAM and bank handoff to the bus reader.
module cam_line_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int LINE_LEN = DEF_LINE_LEN,
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_pix_valid,
  input  logic [PIX_W-1:0]  cam_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [PIX_W-1:0]  ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [PIX_W-1:0]  ram_rdata,
  cam_rd_if.slave           rd,
  output logic              frame_start,
  output logic [8:0]        line_count,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam logic [ADDR_W-1:0] LEN_A = ADDR_W'(LINE_LEN);

  cap_state_t        state;
  logic              vsync_q, href_q;
  logic              vs_rise, vs_fall, href_rise, href_fall;
  logic              wbank, rbank;
  logic [1:0]        full;
  logic [ADDR_W-1:0] pcnt, wbase, rbase;
  logic              line_close, drop_close, ovr_set, rel_bank;

  assign vs_rise   = cam_vsync & ~vsync_q;
  assign vs_fall   = ~cam_vsync & vsync_q;
  assign href_rise = cam_href & ~href_q;
  assign href_fall = ~cam_href & href_q;

  assign wbase = wbank ? LEN_A : '0;
  assign rbase = rbank ? LEN_A : '0;

  // Write strobe follows the pixel strobe in the same cycle; overflow pixels are dropped.
  assign ram_we    = (state == CAPTURE) && cam_pix_valid && cam_href && (pcnt < LEN_A);
  assign ram_waddr = ram_we ? wbase + pcnt : '0;
  assign ram_wdata = ram_we ? cam_data : '0;

  // A vsync abort wins over a same-cycle line close.
  assign line_close = (state == CAPTURE)   && href_fall && !vs_rise;
  assign drop_close = (state == DROP)      && href_fall && !vs_rise;
  assign ovr_set    = (state == WAIT_LINE) && href_rise && full[wbank] && !vs_rise;
  assign rel_bank   = rd.line_done && full[rbank];

  assign rd.line_ready = full[rbank];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      full        <= '0;
      pcnt        <= '0;
      frame_start <= 1'b0;
      line_count  <= '0;
      overrun     <= 1'b0;
    end else begin
      vsync_q     <= cam_vsync;
      href_q      <= cam_href;
      frame_start <= 1'b0;

      if (ram_we)
        pcnt <= pcnt + ADDR_W'(1);

      // set and release always target different banks, so both may land together
      if (line_close)
        full[wbank] <= 1'b1;
      if (rel_bank) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
      end

      if ((line_close || drop_close) && (line_count != 9'h1FF))
        line_count <= line_count + 9'd1;

      if (overrun_clr)
        overrun <= 1'b0;
      else if (ovr_set)
        overrun <= 1'b1;

      if (vs_rise) begin
        state <= IDLE;
        pcnt  <= '0;
      end else begin
        unique case (state)
          IDLE:
            if (vs_fall) begin
              frame_start <= 1'b1;
              line_count  <= '0;
              state       <= WAIT_LINE;
            end
          WAIT_LINE:
            if (href_rise)
              state <= full[wbank] ? DROP : CAPTURE;
          CAPTURE:
            if (href_fall) begin
              wbank <= ~wbank;
              pcnt  <= '0;
              state <= WAIT_LINE;
            end
          DROP:
            if (href_fall)
              state <= WAIT_LINE;
          default:
            state <= IDLE;
        endcase
      end
    end
  end

  cam_rd_port #(
    .LINE_LEN (LINE_LEN),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_rd_port (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd.rd_req),
    .rd_idx     (rd.rd_idx),
    .line_ready (full[rbank]),
    .rbase      (rbase),
    .ram_rdata  (ram_rdata),
    .ram_raddr  (ram_raddr),
    .rd_ack     (rd.rd_ack),
    .rd_data    (rd.rd_data),
    .rd_err     (rd.rd_err)
  );

endmodule

// File: tb/tb_cam_line_ctrl.sv
// Scoreboard bench for cam_line_ctrl with a line-level reference model and a RAM model.
module tb_cam_line_ctrl;
  import cam_ctrl_pkg::*;

  localparam int LL = 120;
  localparam int AW = 8;
  localparam int IW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cam_vsync = 1'b1, cam_href = 1'b0, cam_pix_valid = 1'b0;
  logic [3:0]    cam_data = '0;
  logic          ram_we;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [3:0]    ram_wdata;
  logic [3:0]    ram_rdata = '0;
  logic          frame_start, overrun;
  logic          overrun_clr = 1'b0;
  logic [8:0]    line_count;

  cam_rd_if #(.IDX_W(IW)) rd ();

  cam_line_ctrl #(.LINE_LEN(LL), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_pix_valid(cam_pix_valid), .cam_data(cam_data),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .rd(rd.slave),
    .frame_start(frame_start), .line_count(line_count),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  // registered-read RAM, 1-cycle latency
  logic [3:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // reference model: line-level view of banks and counters
  typedef struct { logic [AW-1:0] addr; logic [3:0] data; } wr_t;
  typedef struct { logic err; logic [3:0] data; int due; } rd_t;
  wr_t wq[$];
  rd_t rq[$];
  bit [3:0] ref_mem [2][LL];
  bit ref_full [2];
  bit ref_w = 0, ref_r = 0, ref_ovr = 0, in_frame = 0;
  int ref_cnt = 0, mode = 0, pc = 0;
  int exp_fs = 0, got_fs = 0, n_wr = 0;

  wr_t mw;
  rd_t mr;
  always @(negedge clk) if (rst_n) begin
    if (frame_start) got_fs++;
    if (ram_we) begin
      n_wr++;
      if (wq.size() == 0) flag("unexpected_write");
      else begin
        mw = wq.pop_front();
        chk("wr_addr", int'(ram_waddr), int'(mw.addr));
        chk("wr_data", int'(ram_wdata), int'(mw.data));
      end
    end
    if (rd.rd_ack) begin
      if (rq.size() == 0) flag("unexpected_rd_ack");
      else begin
        mr = rq.pop_front();
        chk("rd_err", int'(rd.rd_err), int'(mr.err));
        chk("rd_data", int'(rd.rd_data), int'(mr.data));
        chk("rd_latency", cyc, mr.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    ref_full[0] = 0; ref_full[1] = 0;
    ref_w = 0; ref_r = 0; ref_ovr = 0; in_frame = 0;
    ref_cnt = 0; mode = 0; pc = 0;
    wq.delete();
    rq.delete();
  endtask

  task automatic chk_state(string tag);
    chk({tag, ":line_ready"}, int'(rd.line_ready), int'(ref_full[ref_r]));
    chk({tag, ":line_count"}, int'(line_count), ref_cnt);
    chk({tag, ":overrun"}, int'(overrun), int'(ref_ovr));
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ":ram_we"}, int'(ram_we), 0);
    chk({tag, ":ram_waddr"}, int'(ram_waddr), 0);
    chk({tag, ":ram_wdata"}, int'(ram_wdata), 0);
    chk({tag, ":ram_raddr"}, int'(ram_raddr), 0);
    chk({tag, ":rd_ack"}, int'(rd.rd_ack), 0);
    chk({tag, ":rd_data"}, int'(rd.rd_data), 0);
    chk({tag, ":rd_err"}, int'(rd.rd_err), 0);
    chk({tag, ":line_ready"}, int'(rd.line_ready), 0);
    chk({tag, ":frame_start"}, int'(frame_start), 0);
    chk({tag, ":line_count"}, int'(line_count), 0);
    chk({tag, ":overrun"}, int'(overrun), 0);
  endtask

  task automatic vs_rise();
    tick(); cam_vsync = 1'b1;
    mode = 0; in_frame = 0;
    tick(); tick();
  endtask

  task automatic vs_fall();
    tick(); cam_vsync = 1'b0;
    in_frame = 1; ref_cnt = 0; exp_fs++;
    tick(); tick();
  endtask

  task automatic line_begin(input bit clr);
    tick(); cam_href = 1'b1; overrun_clr = clr;
    pc = 0;
    if (!in_frame) mode = 0;
    else if (!ref_full[ref_w]) mode = 1;
    else begin mode = 2; ref_ovr = 1; end
    if (clr) ref_ovr = 0;
  endtask

  task automatic pixel(input logic [3:0] d);
    tick(); cam_pix_valid = 1'b1; cam_data = d; overrun_clr = 1'b0;
    if (mode == 1 && pc < LL) begin
      wq.push_back('{addr: AW'((ref_w ? LL : 0) + pc), data: d});
      ref_mem[ref_w][pc] = d;
    end
    if (mode == 1) pc++;
    tick(); cam_pix_valid = 1'b0;
    if ($urandom_range(3) == 0) tick();
  endtask

  task automatic line_end();
    tick(); cam_href = 1'b0; overrun_clr = 1'b0;
    if (mode == 1) begin ref_full[ref_w] = 1; ref_w = !ref_w; end
    if (mode != 0) ref_cnt = (ref_cnt < 511) ? ref_cnt + 1 : 511;
    mode = 0;
    tick(); tick();
  endtask

  task automatic send_line(input int n, input bit pat);
    line_begin(1'b0);
    for (int i = 0; i < n; i++) pixel(pat ? 4'(i % 16) : 4'($urandom));
    line_end();
  endtask

  task automatic do_done();
    tick(); rd.line_done = 1'b1;
    if (ref_full[ref_r]) begin ref_full[ref_r] = 0; ref_r = !ref_r; end
    tick(); rd.line_done = 1'b0;
  endtask

  task automatic do_read(input int idx, input bit mid_done);
    bit ok;
    int exp_addr;
    tick(); rd.rd_req = 1'b1; rd.rd_idx = IW'(idx);
    ok = ref_full[ref_r] && idx < LL;
    exp_addr = (ref_r ? LL : 0) + idx;
    if (ok) rq.push_back('{err: 1'b0, data: ref_mem[ref_r][idx], due: cyc + 3});
    else    rq.push_back('{err: 1'b1, data: 4'h0, due: cyc + 1});
    tick(); rd.rd_req = 1'b0;
    if (mid_done) begin
      rd.line_done = 1'b1;
      if (ref_full[ref_r]) begin ref_full[ref_r] = 0; ref_r = !ref_r; end
      tick(); rd.line_done = 1'b0;
    end
    for (int t = 0; t < 10 && rq.size() != 0; t++) tick();
    if (rq.size() != 0) begin flag("rd_timeout"); rq.delete(); end
    if (ok) chk("rd_raddr", int'(ram_raddr), exp_addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rd.rd_req = 1'b0; rd.rd_idx = '0; rd.line_done = 1'b0;
    for (int b = 0; b < 2; b++) for (int i = 0; i < LL; i++) ref_mem[b][i] = '0;
    model_reset();
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // first frame, first full line with counting pattern
    vs_fall();
    chk("frame_start_cnt1", got_fs, exp_fs);
    w0 = n_wr;
    send_line(LL, 1'b1);
    chk("line1_writes", n_wr - w0, LL);
    chk_state("line1");

    do_read(5, 1'b0);
    do_read(120, 1'b0);
    do_read(127, 1'b0);
    do_read(119, 1'b0);

    // second line fills bank 1, third is dropped
    send_line(LL, 1'b0);
    w0 = n_wr;
    send_line(LL, 1'b0);
    chk("drop_writes", n_wr - w0, 0);
    chk_state("three_lines");
    tick(); overrun_clr = 1'b1; ref_ovr = 0;
    tick(); overrun_clr = 1'b0;
    tick();
    chk_state("ovr_clr");

    // clear racing a same-cycle overrun set: clear wins
    line_begin(1'b1);
    line_end();
    chk_state("clr_priority");

    do_read(int'($urandom_range(0, LL - 1)), 1'b0);
    do_done();
    chk_state("done1");
    do_read(0, 1'b1);
    chk_state("done2");
    do_read(3, 1'b0);
    do_done();
    chk_state("done_ignored");

    // vsync abort after 50 pixels, then a short line in a new frame
    line_begin(1'b0);
    for (int i = 0; i < 50; i++) pixel(4'($urandom));
    mode = 0;
    vs_rise();
    tick(); cam_href = 1'b0; tick();
    chk_state("abort");
    vs_fall();
    chk("frame_start_cnt2", got_fs, exp_fs);
    send_line(60, 1'b0);
    chk_state("short_line");
    do_read(100, 1'b0);
    do_read(10, 1'b0);

    // reset while a line is being written and a read is in flight
    line_begin(1'b0);
    for (int i = 0; i < 10; i++) pixel(4'($urandom));
    tick(); rd.rd_req = 1'b1; rd.rd_idx = 7'd3;
    tick(); rd.rd_req = 1'b0;
    #2;
    rst_n = 1'b0; cam_href = 1'b0; cam_pix_valid = 1'b0; cam_vsync = 1'b1; rd.line_done = 1'b0;
    #1;
    chk_zero("mid_reset");
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    vs_fall();
    send_line(125, 1'b0);
    chk_state("post_reset");
    do_read(int'($urandom_range(0, LL - 1)), 1'b0);

    // randomized mix of lines, releases, reads and frame restarts
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0, 1: send_line(int'($urandom_range(0, 130)), 1'b0);
        2: do_done();
        3: do_read(int'($urandom_range(0, 127)), $urandom_range(0, 3) == 0);
        default: if ($urandom_range(0, 1) == 0) begin
                   tick(); overrun_clr = 1'b1; ref_ovr = 0; tick(); overrun_clr = 1'b0;
                 end else begin
                   vs_rise(); vs_fall();
                 end
      endcase
      chk_state("random");
    end

    // line_count saturation
    vs_rise(); vs_fall();
    for (int i = 0; i < 515; i++) begin line_begin(1'b0); line_end(); end
    chk_state("saturate");

    repeat (4) tick();
    chk("frame_start_total", got_fs, exp_fs);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
